// File: rtl/digit_serial_alu.sv
// digit_serial_alu
//   Digit-serial integer ALU. One request is accepted in IDLE. The operands
//   are then streamed LSB-first through a DIGIT-wide adder/logic slice, one
//   digit per RUN cycle. A 1-bit carry register links consecutive digits.
//   The registered result is presented in DONE until the consumer takes it.
//
//   Optional feature macro: DSALU_CMP_EN
//     When defined, the cmp_eq/cmp_lt ports and the digit-wise compare
//     accumulators are built in.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   req_valid   request present
//   req_ready   block can accept (IDLE only)
//   a, b        operands (XLEN)
//   alu_op      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLTU
//   resp_valid  result available (DONE)
//   resp_ready  consumer accepts result
//   result      registered result (XLEN)
//   cout        final carry of ADD/SUB, 0 otherwise
//   dbg_state   current FSM state (0 IDLE, 1 RUN, 2 DONE)
//   cmp_eq      a == b                       (DSALU_CMP_EN only)
//   cmp_lt      a < b, signed only for SLT   (DSALU_CMP_EN only)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and data stable until that edge.
module digit_serial_alu #(
    parameter int XLEN  = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [2:0]       alu_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  result,
    output logic             cout,
    output logic [1:0]       dbg_state
`ifdef DSALU_CMP_EN
    ,
    output logic             cmp_eq,
    output logic             cmp_lt
`endif
);

    localparam int N  = XLEN / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [XLEN-1:0] a_q;      // shifts out operand A, shifts in result digits
    logic [XLEN-1:0] b_q;
    logic [2:0]      op_q;
    logic            carry;
    logic [CW-1:0]   cnt;

    logic [DIGIT-1:0]      a_d, b_raw, b_d, dig;
    logic [DIGIT:0]        sum;
    logic [XLEN+DIGIT-1:0] cat;
    logic [XLEN-1:0]       acc_next, final_res;
    logic                  ovf, slt_bit, sltu_bit, final_cout, last;

    // Subtract-type ops invert B and seed the carry with 1 (two's complement).
    function automatic logic uses_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = S_RUN;
            end
            S_RUN: begin
                if (last) next_state = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign dbg_state = state;
    assign last      = (cnt == LAST);

    // ---------------- digit slice ----------------
    always_comb begin
        a_d      = a_q[DIGIT-1:0];
        b_raw    = b_q[DIGIT-1:0];
        b_d      = b_raw ^ {DIGIT{uses_sub(op_q)}};
        sum      = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
        dig      = '0;
        case (op_q)
            OP_ADD, OP_SUB, OP_SLT, OP_SLTU: dig = sum[DIGIT-1:0];
            OP_AND:  dig = a_d & b_raw;
            OP_OR:   dig = a_d | b_raw;
            OP_XOR:  dig = a_d ^ b_raw;
            default: dig = '0;
        endcase
        // New digit enters at the top while operand A drains from the bottom.
        cat      = {dig, a_q};
        acc_next = cat[XLEN+DIGIT-1:DIGIT];
        // Only meaningful on the last (most significant) digit.
        ovf      = (a_d[DIGIT-1] == b_d[DIGIT-1]) && (sum[DIGIT-1] != a_d[DIGIT-1]);
        slt_bit  = sum[DIGIT-1] ^ ovf;
        sltu_bit = ~sum[DIGIT];
        case (op_q)
            OP_SLT:  final_res = {{(XLEN-1){1'b0}}, slt_bit};
            OP_SLTU: final_res = {{(XLEN-1){1'b0}}, sltu_bit};
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: final_res = acc_next;
            default: final_res = '0;
        endcase
        final_cout = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? sum[DIGIT] : 1'b0;
    end

`ifdef DSALU_CMP_EN
    logic eq_acc, lt_acc, eq_next, lt_next;

    // Higher digits override the running unsigned less-than from lower ones.
    always_comb begin
        eq_next = eq_acc & (a_d == b_raw);
        lt_next = (a_d < b_raw) | ((a_d == b_raw) & lt_acc);
    end
`endif

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
`ifdef DSALU_CMP_EN
            eq_acc <= 1'b0;
            lt_acc <= 1'b0;
            cmp_eq <= 1'b0;
            cmp_lt <= 1'b0;
`endif
        end else begin
            if (state == S_IDLE && req_valid) begin
                a_q    <= a;
                b_q    <= b;
                op_q   <= alu_op;
                carry  <= uses_sub(alu_op);
                cnt    <= '0;
`ifdef DSALU_CMP_EN
                eq_acc <= 1'b1;
                lt_acc <= 1'b0;
`endif
            end else if (state == S_RUN) begin
                a_q   <= acc_next;
                b_q   <= b_q >> DIGIT;
                carry <= sum[DIGIT];
                cnt   <= cnt + CW'(1);
`ifdef DSALU_CMP_EN
                eq_acc <= eq_next;
                lt_acc <= lt_next;
`endif
                if (last) begin
                    result <= final_res;
                    cout   <= final_cout;
`ifdef DSALU_CMP_EN
                    cmp_eq <= eq_next;
                    cmp_lt <= (op_q == OP_SLT) ? slt_bit : lt_next;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_alu.sv
// Testbench for digit_serial_alu. Three instances (DIGIT = 4, 1, 32) share
// the clock, reset and operand buses; each has its own valid/ready pair.
module tb_digit_serial_alu;

    localparam int XLEN = 32;
    localparam int NI   = 3;
    localparam int EW   = XLEN + 3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            req_valid  [NI];
    logic            resp_ready [NI];
    logic [XLEN-1:0] a, b;
    logic [2:0]      alu_op;
    logic            req_ready  [NI];
    logic            resp_valid [NI];
    logic [XLEN-1:0] result     [NI];
    logic            cout       [NI];
    logic [1:0]      dbg_state  [NI];
`ifdef DSALU_CMP_EN
    logic            cmp_eq     [NI];
    logic            cmp_lt     [NI];
`endif

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DG = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
        digit_serial_alu #(.XLEN(XLEN), .DIGIT(DG)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .a          (a),
            .b          (b),
            .alu_op     (alu_op),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .result     (result[g]),
            .cout       (cout[g]),
            .dbg_state  (dbg_state[g])
`ifdef DSALU_CMP_EN
            ,
            .cmp_eq     (cmp_eq[g]),
            .cmp_lt     (cmp_lt[g])
`endif
        );
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];   // {cmp_lt, cmp_eq, cout, result}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 32 : 1);
    endfunction

    function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y);
        logic [XLEN:0]   s;
        logic [XLEN-1:0] r;
        logic c, eq, lt, slt_s, ult;
        s     = '0;
        r     = '0;
        c     = 1'b0;
        slt_s = ($signed(x) < $signed(y));
        ult   = (x < y);
        case (op)
            OP_ADD:  begin s = {1'b0, x} + {1'b0, y};               r = s[XLEN-1:0]; c = s[XLEN]; end
            OP_SUB:  begin s = {1'b0, x} + {1'b0, ~y} + 33'd1;      r = s[XLEN-1:0]; c = s[XLEN]; end
            OP_AND:  r = x & y;
            3'b011:  r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, slt_s};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, ult};
            default: r = '0;
        endcase
        eq = (x == y);
        lt = (op == OP_SLT) ? slt_s : ult;
        return {lt, eq, c, r};
    endfunction

    // ---------------- driver ----------------
    // Starts and ends just after a rising edge. hold = cycles of resp_ready low
    // in DONE; keep_valid leaves req_valid high with scrambled operands.
    task automatic run_op(input int i, input logic [2:0] op, input logic [XLEN-1:0] x,
                          input logic [XLEN-1:0] y, input int hold, input bit keep_valid,
                          output int acc_wait);
        logic [EW-1:0] e;
        int lat;
        bit ok;
        alu_op        = op;
        a             = x;
        b             = y;
        req_valid[i]  = 1'b1;
        resp_ready[i] = (hold == 0);
        acc_wait = 0;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc_wait++;
            if (req_ready[i]) begin ok = 1; break; end
        end
        check("accept_timeout", 64'(ok), 64'd1);
        if (!ok) return;
        @(posedge clk);
        exp_q.push_back(model(op, x, y));
        #1;
        if (keep_valid) begin
            a      = $urandom;
            b      = $urandom;
            alu_op = 3'($urandom_range(0, 7));
        end else begin
            req_valid[i] = 1'b0;
        end
        ok  = 0;
        lat = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (resp_valid[i]) begin ok = 1; break; end
        end
        check("resp_timeout", 64'(ok), 64'd1);
        check("latency", 64'(lat), 64'(lat_of(i)));
        if (!ok) return;
        e = exp_q.pop_front();
        check("result", 64'(result[i]), 64'(e[XLEN-1:0]));
        check("cout", 64'(cout[i]), 64'(e[XLEN]));
`ifdef DSALU_CMP_EN
        check("cmp_eq", 64'(cmp_eq[i]), 64'(e[XLEN+1]));
        check("cmp_lt", 64'(cmp_lt[i]), 64'(e[XLEN+2]));
`endif
        check("req_ready_done", 64'(req_ready[i]), 64'd0);
        check("state_done", 64'(dbg_state[i]), 64'd2);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 64'(resp_valid[i]), 64'd1);
            check("hold_result", 64'(result[i]), 64'(e[XLEN-1:0]));
            check("hold_req_ready", 64'(req_ready[i]), 64'd0);
        end
        resp_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready_after", 64'(req_ready[i]), 64'd1);
        check("resp_valid_after", 64'(resp_valid[i]), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int seen;
        logic [2:0] rop;
        rst = 1'b0;
        a = '0;
        b = '0;
        alu_op = '0;
        for (int i = 0; i < NI; i++) begin
            req_valid[i]  = 1'b0;
            resp_ready[i] = 1'b1;
        end
        #1;
        check("rst_req_ready", 64'(req_ready[0]), 64'd1);
        check("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
        check("rst_result", 64'(result[0]), 64'd0);
        check("rst_cout", 64'(cout[0]), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors on DIGIT=4
        run_op(0, OP_ADD,  32'hFFFF_FFFF, 32'h1, 0, 0, w);
        run_op(0, OP_SUB,  32'd5, 32'd7, 0, 0, w);
        run_op(0, OP_SLT,  32'h8000_0000, 32'h1, 0, 0, w);
        run_op(0, OP_SLTU, 32'h8000_0000, 32'h1, 0, 0, w);
        run_op(0, OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 5, 0, w);

        // Back-to-back with req_valid held high
        run_op(0, OP_ADD, 32'd1, 32'd2, 0, 1, w);
        run_op(0, OP_AND, 32'hF0, 32'h3C, 0, 0, w);
        check("b2b_accept_wait", 64'(w), 64'd1);

        // Random mix including reserved op and equal operands
        for (int k = 0; k < 16; k++) begin
            rop = 3'($urandom_range(0, 7));
            if (k % 5 == 0) begin
                a = $urandom;
                run_op(0, rop, a, a, $urandom_range(0, 2), 0, w);
            end else begin
                run_op(0, rop, $urandom, $urandom, $urandom_range(0, 2), 0, w);
            end
        end

        // Abort by reset in the middle of RUN
        alu_op = OP_ADD;
        a = 32'd100;
        b = 32'd200;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_state_run", 64'(dbg_state[0]), 64'd1);
        rst = 1'b0;
        #1;
        check("abort_req_ready", 64'(req_ready[0]), 64'd1);
        check("abort_resp_valid", 64'(resp_valid[0]), 64'd0);
        check("abort_result", 64'(result[0]), 64'd0);
        check("abort_cout", 64'(cout[0]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid[0]) seen++;
        end
        check("abort_no_resp", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        run_op(0, OP_ADD, 32'd10, 32'd20, 0, 0, w);

        // Same vectors with DIGIT=1 and DIGIT=32
        for (int i = 1; i < NI; i++) begin
            run_op(i, OP_ADD,  32'hFFFF_FFFF, 32'h1, 0, 0, w);
            run_op(i, OP_SUB,  32'd5, 32'd7, 0, 0, w);
            run_op(i, OP_SLT,  32'h8000_0000, 32'h1, 0, 0, w);
            run_op(i, OP_SLTU, 32'h8000_0000, 32'h1, 1, 0, w);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_serial_alu.md
DIGIT_SERIAL_ALU -- requirements
Module: digit_serial_alu

Interface
REQ-001 Parameter XLEN, 32, operand/result width.
REQ-002 Parameter DIGIT, 4, bits processed per cycle; power of two, 1..XLEN, divides XLEN; N = XLEN/DIGIT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept; high only in IDLE.
REQ-007 a  input  XLEN  operand A (rs1 side).
REQ-008 b  input  XLEN  operand B (rs2/imm side).
REQ-009 alu_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLTU, 111 reserved.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer accepts result.
REQ-012 result  output  XLEN  operation result.
REQ-013 cout  output  1  final carry-out of ADD/SUB; 0 for all other ops.
REQ-014 cmp_eq, cmp_lt  output  1 each  a==b; a<b (signed for SLT, unsigned otherwise); present only with DSALU_CMP_EN.

Function
REQ-015 FSM states IDLE, RUN, DONE; IDLE->RUN on req_valid&&req_ready; RUN->DONE after N digit cycles; DONE->IDLE on resp_valid&&resp_ready.
REQ-016 On accept: a, b, alu_op captured; later input changes ignored until next accept.
REQ-017 Digits processed LSB first, one per RUN cycle, through a DIGIT-wide adder/logic unit with a 1-bit carry register chained between digits.
REQ-018 SUB, SLT, SLTU: b inverted and carry register initialised to 1; otherwise carry initialised to 0.
REQ-019 Latency: resp_valid rises exactly N rising edges after the accepting edge; DIGIT=XLEN gives 1-cycle latency.
REQ-020 ADD/SUB result is modulo 2^XLEN; AND/OR/XOR bitwise.
REQ-021 SLT: result = {XLEN-1 zeros, sign(a-b) XOR signed-overflow}; SLTU: result = {XLEN-1 zeros, NOT final carry}.
REQ-022 Op 111: result 0, cout 0, same latency and handshake.
REQ-023 In DONE, result/cout/cmp outputs held stable while resp_ready low (backpressure unbounded).
REQ-024 req_ready low in RUN and DONE; no overlap; req_ready high the cycle after the response handshake.
REQ-025 req_valid during RUN/DONE ignored; no request lost if held (valid/ready semantics).
REQ-026 Outputs result/cout/cmp_* are registered; values outside DONE are don't-care to the consumer but retain the last result.

Reset
REQ-027 rst low forces IDLE immediately: req_ready 1, resp_valid 0, result 0, cout 0, cmp_eq 0, cmp_lt 0, carry and digit counter 0.
REQ-028 Reset during RUN or DONE aborts the operation; no response is produced for it.
REQ-029 Operation resumes on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro DSALU_CMP_EN: defined -> cmp_eq/cmp_lt ports and digit-wise equality accumulator present, cmp_eq/cmp_lt valid in DONE for every op (cmp_lt signed only for SLT).
REQ-031 DSALU_CMP_EN undefined -> cmp_eq/cmp_lt ports and equality logic absent; SLT/SLTU results unaffected.

Verification (XLEN=32, DIGIT=4, N=8 unless stated)
REQ-032 ADD a=0xFFFF_FFFF b=0x0000_0001, resp_ready=1 -> resp_valid 8 edges after accept, result 0x0000_0000, cout 1.
REQ-033 SUB a=5 b=7; then SLT a=0x8000_0000 b=1; SLTU same operands -> results 0xFFFF_FFFE (cout 0), 1, 0; with DSALU_CMP_EN cmp_eq 0.
REQ-034 XOR a=0xA5A5_A5A5 b=0xFFFF_0000, resp_ready low 5 cycles -> result 0x5A5A_A5A5 stable all 5 cycles, req_ready low until cycle after handshake.
REQ-035 Back-to-back req_valid held high for ADD(1,2) then AND(0xF0,0x3C) -> results 3 then 0x30, second accept one cycle after first response handshake.
REQ-036 rst low at RUN digit 4 -> req_ready 1, resp_valid 0 immediately; no response; following ADD(10,20) returns 30.
REQ-037 Rerun REQ-032/033 with DIGIT=1 (N=32) and DIGIT=32 (N=1) -> identical results, latency 32 and 1.
